uop_issue_queue: RTL
====================

// Module: uop_issue_queue
// PURPOSE
//   Micro-op buffer directly downstream of the decode stage. Accepts a group of 1-3 uops
//   per decoded instruction through the feed_req/feed_ack handshake and replays them in
//   program order to the execute stage, one uop per cycle. Marks the last uop of each
//   instruction and supports a pipeline flush on branch or PC redirect.
// PARAMETERS
//   DEPTH   8   entry count; power of two, minimum 4
//   UOP_W   20  micro-op width in bits
// PORTS
//   clk        in   1                 clock, rising edge
//   a_rst      in   1                 asynchronous reset, active-high
//   flush      in   1                 synchronous flush of all buffered uops
//   feed_req   out  1                 queue can accept a full 3-uop group
//   feed_ack   in   1                 decode pushes a group this cycle
//   uop_0      in   UOP_W             final uop of the group (ALU/writeback step)
//   uop_1      in   UOP_W             middle uop
//   uop_2      in   UOP_W             first uop
//   uop_count  in   2                 00: 1 uop, 01: 2 uops, 10: 3 uops
//   uop_valid  out  1                 uop_out holds a valid uop
//   uop_out    out  UOP_W             head uop
//   uop_last   out  1                 head uop is the last uop of its instruction
//   uop_ready  in   1                 execute accepts the head uop
//   occupancy  out  $clog2(DEPTH)+1   number of buffered entries
// BEHAVIOUR
//   - Reset (a_rst=1, asynchronous): pointers and count cleared; uop_valid=0,
//     uop_out=0, uop_last=0, occupancy=0. feed_req=1 once reset is released.
//   - Entry format: {last, uop}. Circular buffer with wr_ptr/rd_ptr modulo DEPTH.
//     Pointer wrap is natural; a push group may straddle the wrap point.
//   - Push order by uop_count:
//       10 -> uop_2, uop_1, uop_0
//       01 -> uop_1, uop_0
//       00 -> uop_0
//     Only uop_0 is written with last=1. uop_count=11 is handled exactly like 10.
//   - feed_req = (DEPTH - occupancy) >= 3. It is combinational from registered state only
//     and does not count a same-cycle pop. A feed_ack while feed_req=0 is a protocol error;
//     the push is dropped and no state changes.
//   - Pop: when uop_valid & uop_ready, rd_ptr advances by 1 and occupancy decrements by 1.
//     Push and pop in the same cycle are both honoured:
//     occupancy_next = occupancy + n_push - pop.
//   - uop_valid = (occupancy != 0). uop_out and uop_last read the head entry
//     combinationally. Default push-to-valid latency is 1 cycle.
//   - Flush has priority over push and pop. Next cycle: occupancy=0, uop_valid=0.
//     The same-cycle push and pop are discarded.
//   - Reset mid-group: all buffered uops are lost; there is no partial-group recovery.
// CONFIGURATION
//   UOPQ_BYPASS_EN defined:
//     - When occupancy==0, feed_ack=1 and flush=0, the first uop of the incoming group
//       appears on uop_out/uop_last with uop_valid=1 in the same cycle.
//     - If uop_ready=1 in that cycle, the first uop is not written into the buffer; only
//       the remaining uops are.
//     - This introduces a combinational path from feed_ack/uop_* to uop_out.
//   UOPQ_BYPASS_EN undefined:
//     - No bypass; uop_valid rises one cycle after the push. No combinational input-to-
//       output path exists except uop_ready -> nothing (outputs are state-only).
// TESTING
//   1. Reset released, push count=00 uop_0=20'hABCDE, uop_ready=1
//      -> next cycle uop_valid=1, uop_out=20'hABCDE, uop_last=1; following cycle
//      uop_valid=0.
//   2. Push count=10 (u2=1, u1=2, u0=3), uop_ready=1
//      -> uop_out 1, 2, 3 on consecutive cycles with uop_last 0, 0, 1; occupancy peaks at 3.
//   3. DEPTH=8, uop_ready=0, push two 3-uop groups
//      -> occupancy=6, feed_req=0. Pop one -> occupancy=5, feed_req=1.
//   4. Fill to wr_ptr=6, then push 3 uops
//      -> entries land at 6, 7, 0 (wrap); popped in order, data intact.
//   5. occupancy=4, assert flush together with feed_ack and uop_ready
//      -> next cycle occupancy=0, uop_valid=0, feed_req=1.
//   6. UOPQ_BYPASS_EN, empty queue, push count=01 (u1=7, u0=8) with uop_ready=1
//      -> same cycle uop_out=7; next cycle uop_out=8, uop_last=1.

Source files
------------

// File: rtl/uop_issue_queue.sv
// Micro-op issue queue: accepts 1-3 uop groups from decode, replays them in order one per cycle.
// Optional same-cycle bypass of the first uop into an empty queue when UOPQ_BYPASS_EN is defined.
module uop_issue_queue #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned UOP_W = 20
) (
    input  logic                     clk,
    input  logic                     a_rst,
    input  logic                     flush,
    output logic                     feed_req,
    input  logic                     feed_ack,
    input  logic [UOP_W-1:0]         uop_0,
    input  logic [UOP_W-1:0]         uop_1,
    input  logic [UOP_W-1:0]         uop_2,
    input  logic [1:0]               uop_count,
    output logic                     uop_valid,
    output logic [UOP_W-1:0]         uop_out,
    output logic                     uop_last,
    input  logic                     uop_ready,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned EW = UOP_W + 1;
    localparam logic [AW:0] MAX_FILL = (AW + 1)'(DEPTH - 3);

    logic [EW-1:0] mem_q [DEPTH];
    logic [EW-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;

    // Group in program order: grp[0] is issued first; grp[3] is a zero pad for indexing.
    logic [EW-1:0] grp [4];
    logic [1:0]    n_grp;
    logic [1:0]    n_wr;
    logic          skip;
    logic          empty;
    logic          push_ok;
    logic          pop_buf;
    logic          head_valid;
    logic [EW-1:0] head;

    always_comb begin
        grp[0] = '0;
        grp[1] = '0;
        grp[2] = '0;
        grp[3] = '0;
        n_grp  = 2'd3;
        unique case (uop_count)
            2'b00: begin
                grp[0] = {1'b1, uop_0};
                n_grp  = 2'd1;
            end
            2'b01: begin
                grp[0] = {1'b0, uop_1};
                grp[1] = {1'b1, uop_0};
                n_grp  = 2'd2;
            end
            default: begin
                grp[0] = {1'b0, uop_2};
                grp[1] = {1'b0, uop_1};
                grp[2] = {1'b1, uop_0};
                n_grp  = 2'd3;
            end
        endcase
    end

    assign empty    = (count_q == '0);
    assign feed_req = (count_q <= MAX_FILL);
    assign push_ok  = feed_ack & feed_req & ~flush;
    assign pop_buf  = ~empty & uop_ready;

`ifdef UOPQ_BYPASS_EN
    logic byp;
    // feed_req is always high when empty, so the bypass never needs to check it.
    assign byp        = empty & feed_ack & ~flush;
    assign skip       = byp & uop_ready;
    assign head_valid = ~empty | byp;
    assign head       = empty ? (byp ? grp[0] : '0) : mem_q[rd_ptr_q];
`else
    assign skip       = 1'b0;
    assign head_valid = ~empty;
    assign head       = empty ? '0 : mem_q[rd_ptr_q];
`endif

    assign n_wr = push_ok ? (n_grp - {1'b0, skip}) : 2'd0;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q + AW'(n_wr);
        rd_ptr_d = rd_ptr_q + AW'(pop_buf);
        count_d  = count_q + (AW + 1)'(n_wr) - (AW + 1)'(pop_buf);
        for (int k = 0; k < 3; k++) begin
            if (2'(k) < n_wr) begin
                mem_d[wr_ptr_q + AW'(k)] = grp[2'(k) + {1'b0, skip}];
            end
        end
        if (flush) begin
            mem_d    = mem_q;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign uop_valid = head_valid;
    assign uop_out   = head[UOP_W-1:0];
    assign uop_last  = head[UOP_W];
    assign occupancy = count_q;

endmodule
